// File: rtl/mul_sched_if.sv
// rtl/mul_sched_if.sv - requester and datapath signal bundle for mul_sched
// Purpose: groups the requester-facing and datapath-facing signals of the
//          shared-multiplier scheduler.
// Ports (modport slave = scheduler view):
//   req/a_in/b_in    requester levels and operand slices (slice i = [i*W +: W])
//   gnt/busy         one-hot grant and activity flag
//   lda/ldb/ldp/clrp/decb/data_bus  datapath controls and data
//   eqz/dp_p         datapath counter-zero flag and product value
//   done/done_id/result  completion pulse, requester ID and product
interface mul_sched_if #(
   parameter int N_REQ = 4,
   parameter int W     = 16
);
   localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]   req;
   logic [N_REQ*W-1:0] a_in;
   logic [N_REQ*W-1:0] b_in;
   logic [N_REQ-1:0]   gnt;
   logic               busy;
   logic               lda;
   logic               ldb;
   logic               ldp;
   logic               clrp;
   logic               decb;
   logic [W-1:0]       data_bus;
   logic               eqz;
   logic [W-1:0]       dp_p;
   logic               done;
   logic [IDW-1:0]     done_id;
   logic [W-1:0]       result;

   modport master (
      output req, a_in, b_in, eqz, dp_p,
      input  gnt, busy, lda, ldb, ldp, clrp, decb, data_bus, done, done_id, result
   );

   modport slave (
      input  req, a_in, b_in, eqz, dp_p,
      output gnt, busy, lda, ldb, ldp, clrp, decb, data_bus, done, done_id, result
   );
endinterface

// File: rtl/mul_sched.sv
// rtl/mul_sched.sv - round-robin scheduler for a shared repeated-addition multiplier
// Purpose: arbitrates N_REQ requesters, latches the winner's operands and
//          sequences one shared datapath (A reg, down-counter, product reg).
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   sif    mul_sched_if.slave: requests/operands in, grant/controls/result out
module mul_sched #(
   parameter int N_REQ = 4,
   parameter int W     = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   mul_sched_if.slave  sif
);
   localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LDA,
      S_LDB,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [IDW-1:0]   last_q, last_d;
   logic [IDW-1:0]   id_q, id_d;
   logic [IDW-1:0]   done_id_q, done_id_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic [W-1:0]     result_q, result_d;

   logic             win_found;
   logic [IDW-1:0]   win_id;
   int               idx;

   // Round-robin pick: first set request starting just above the last winner.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      idx       = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = (int'(last_q) + k) % N_REQ;
         if (!win_found && sif.req[idx[IDW-1:0]]) begin
            win_found = 1'b1;
            win_id    = idx[IDW-1:0];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      gnt_d        = gnt_q;
      last_d       = last_q;
      id_d         = id_q;
      done_id_d    = done_id_q;
      a_d          = a_q;
      b_d          = b_q;
      result_d     = result_q;
      sif.lda      = 1'b0;
      sif.ldb      = 1'b0;
      sif.ldp      = 1'b0;
      sif.clrp     = 1'b0;
      sif.decb     = 1'b0;
      sif.done     = 1'b0;
      sif.data_bus = '0;
      case (state_q)
         S_IDLE: begin
            if (win_found) begin
               gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << win_id;
               id_d    = win_id;
               last_d  = win_id;
               a_d     = sif.a_in[win_id*W +: W];
               b_d     = sif.b_in[win_id*W +: W];
               state_d = S_LDA;
            end
         end
         S_LDA: begin
            sif.data_bus = a_q;
            sif.lda      = 1'b1;
            state_d      = S_LDB;
         end
         S_LDB: begin
            // Loading the counter and clearing P in the same cycle starts the run.
            sif.data_bus = b_q;
            sif.ldb      = 1'b1;
            sif.clrp     = 1'b1;
            state_d      = S_RUN;
         end
         S_RUN: begin
            if (!sif.eqz) begin
               sif.ldp  = 1'b1;
               sif.decb = 1'b1;
            end else begin
               // P already holds the final sum here; capture it on the way out.
               result_d  = sif.dp_p;
               done_id_d = id_q;
               state_d   = S_DONE;
            end
         end
         S_DONE: begin
            sif.done = 1'b1;
            gnt_d    = '0;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         gnt_q     <= '0;
         last_q    <= IDW'(N_REQ - 1);
         id_q      <= '0;
         done_id_q <= '0;
         a_q       <= '0;
         b_q       <= '0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         last_q    <= last_d;
         id_q      <= id_d;
         done_id_q <= done_id_d;
         a_q       <= a_d;
         b_q       <= b_d;
         result_q  <= result_d;
      end
   end

   assign sif.gnt     = gnt_q;
   assign sif.busy    = (state_q != S_IDLE);
   assign sif.done_id = done_id_q;
   assign sif.result  = result_q;
endmodule

// File: tb/tb_mul_sched.sv
// tb/tb_mul_sched.sv - directed self-checking bench for mul_sched
module tb_mul_sched;
   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   mul_sched_if #(.N_REQ(4), .W(16)) sif ();

   mul_sched #(.N_REQ(4), .W(16)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sif   (sif.slave)
   );

   always #5 clk = ~clk;

   // Behavioural datapath: A register, down-counter, product register.
   logic [15:0] dp_a   = '0;
   logic [15:0] dp_cnt = '0;
   logic [15:0] dp_pr  = '0;
   always @(posedge clk) begin
      if (sif.lda) dp_a <= sif.data_bus;
      if (sif.ldb) dp_cnt <= sif.data_bus;
      else if (sif.decb) dp_cnt <= dp_cnt - 16'd1;
      if (sif.clrp) dp_pr <= '0;
      else if (sif.ldp) dp_pr <= dp_pr + dp_a;
   end
   assign sif.eqz  = (dp_cnt == 16'd0);
   assign sif.dp_p = dp_pr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Invariants sampled every cycle.
   always @(negedge clk) begin
      check("gnt_onehot0", 32'($onehot0(sif.gnt)), 32'd1);
      check("ctl_invariant",
            {29'd0, sif.lda & sif.ldb, sif.clrp & ~sif.ldb,
             (sif.ldp | sif.decb) & (sif.lda | sif.ldb | sif.done | ~sif.busy)},
            32'd0);
   end

   task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
      sif.a_in[i*16 +: 16] = a;
      sif.b_in[i*16 +: 16] = b;
   endtask

   // Called at a negedge already inside the operation (cycle number start).
   task automatic wait_done(input int start, input int maxc,
                            output int cyc, output int ldp_n, output int gnt_n);
      cyc   = start;
      ldp_n = 0;
      gnt_n = 0;
      while (cyc <= maxc) begin
         if (sif.ldp) ldp_n++;
         if (sif.gnt != '0) gnt_n++;
         if (sif.done) break;
         @(negedge clk);
         cyc++;
      end
      if (!sif.done) check("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_op(input string tag, input int idx, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] exp_res);
      int cyc, ldp_n, gnt_n;
      set_op(idx, a, b);
      sif.req = 4'b0001 << idx;
      @(negedge clk);
      sif.req = '0;
      check({tag, "_gnt"}, 32'(sif.gnt), 32'(4'b0001 << idx));
      check({tag, "_lda_bus"}, {15'd0, sif.lda, sif.data_bus}, {15'd0, 1'b1, a});
      wait_done(1, int'(b) + 100, cyc, ldp_n, gnt_n);
      check({tag, "_latency"}, 32'(cyc), 32'(int'(b) + 4));
      check({tag, "_ldp_cycles"}, 32'(ldp_n), 32'(b));
      check({tag, "_gnt_cycles"}, 32'(gnt_n), 32'(int'(b) + 4));
      check({tag, "_done_id"}, 32'(sif.done_id), 32'(idx));
      check({tag, "_result"}, 32'(sif.result), 32'(exp_res));
      @(negedge clk);
      check({tag, "_idle_after"}, {30'd0, sif.busy, sif.done}, 32'd0);
   endtask

   initial begin
      int cyc, ldp_n, gnt_n, exp_id;
      rst_n    = 1'b0;
      sif.req  = '0;
      sif.a_in = '0;
      sif.b_in = '0;
      repeat (2) @(negedge clk);
      check("rst_busy_gnt", {27'd0, sif.busy, sif.gnt}, 32'd0);
      check("rst_ctl", {26'd0, sif.lda, sif.ldb, sif.ldp, sif.clrp, sif.decb, sif.done}, 32'd0);
      check("rst_bus_res", {sif.data_bus, sif.result}, 32'd0);
      check("rst_done_id", 32'(sif.done_id), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Round robin with all four requesting, B=1.
      for (int i = 0; i < 4; i++) set_op(i, 16'(10 * (i + 1)), 16'd1);
      sif.req = 4'hF;
      @(negedge clk);
      for (int op = 0; op < 5; op++) begin
         exp_id = op % 4;
         check("rr_gnt", 32'(sif.gnt), 32'(4'b0001 << exp_id));
         if (op == 4) sif.req = '0;
         wait_done(1, 50, cyc, ldp_n, gnt_n);
         check("rr_latency", 32'(cyc), 32'd5);
         check("rr_done_id", 32'(sif.done_id), 32'(exp_id));
         check("rr_result", 32'(sif.result), 32'(10 * (exp_id + 1)));
         @(negedge clk);
         check("rr_idle_gap", 32'(sif.busy), 32'd0);
         if (op < 4) begin
            @(negedge clk);
            check("rr_busy_again", 32'(sif.busy), 32'd1);
         end
      end

      run_op("single", 0, 16'd7, 16'd5, 16'd35);
      run_op("b_zero", 0, 16'd9, 16'd0, 16'd0);
      run_op("a_zero", 0, 16'd0, 16'd4, 16'd0);
      run_op("wrap", 0, 16'd300, 16'd300, 16'd24464);

      // Request and operands change during RUN; the operation in flight is unaffected.
      set_op(1, 16'd3, 16'd6);
      sif.req = 4'b0010;
      repeat (4) @(negedge clk);
      sif.req = '0;
      set_op(1, 16'd99, 16'd1);
      wait_done(4, 100, cyc, ldp_n, gnt_n);
      check("midop_latency", 32'(cyc), 32'd10);
      check("midop_done_id", 32'(sif.done_id), 32'd1);
      check("midop_result", 32'(sif.result), 32'd18);
      @(negedge clk);

      // Reset while in RUN.
      set_op(0, 16'd5, 16'd10);
      sif.req = 4'b0001;
      repeat (4) @(negedge clk);
      sif.req = '0;
      check("pre_rst_run", {30'd0, sif.ldp, sif.busy}, 32'd3);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_busy_gnt", {27'd0, sif.busy, sif.gnt}, 32'd0);
      check("midrst_ctl", {26'd0, sif.lda, sif.ldb, sif.ldp, sif.clrp, sif.decb, sif.done}, 32'd0);
      check("midrst_bus_res", {sif.data_bus, sif.result}, 32'd0);
      check("midrst_done_id", 32'(sif.done_id), 32'd0);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("midrst_no_done", {30'd0, sif.done, sif.busy}, 32'd0);
      end
      run_op("after_rst", 2, 16'd4, 16'd2, 16'd8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got %0d expected %0d", 0, 1);
      $fatal(1);
   end
endmodule
